// File: rtl/decryptor_pkg.sv
// ============================================================================
// Module   : decryptor_pkg
// Purpose  : AES-128 shared definitions: FSM encoding, Rcon, S-boxes, GF(2^8)
// Revision : 1.0
// ============================================================================
`default_nettype none

package decryptor_pkg;

  localparam int c_nr_aes128 = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXPAND = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4
  } fsm_t;

  // Multiplication by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0, as AES requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte n of a column-major 128-bit block; byte 0 is the MSB
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int n);
    return s[127 - 8*n -: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/inv_round.sv
// ============================================================================
// Module   : inv_round
// Purpose  : InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns
// Revision : 1.0
// ============================================================================
`default_nettype none

module inv_round
  import decryptor_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_mix_en,
  output logic [127:0] o_state
);

  logic [7:0] w_ak [16];

  // Row r of column c is fed from column (c - r) mod 4 of the input
  for (genvar n = 0; n < 16; n++) begin : g_byte
    localparam int c_row = n % 4;
    localparam int c_col = n / 4;
    localparam int c_src = 4 * ((c_col - c_row + 4) % 4) + c_row;
    assign w_ak[n] = inv_sbox(get_byte(i_state, c_src)) ^ get_byte(i_rk, n);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0]  w_a0, w_a1, w_a2, w_a3;
    logic [31:0] w_mix;
    assign w_a0 = w_ak[4*c + 0];
    assign w_a1 = w_ak[4*c + 1];
    assign w_a2 = w_ak[4*c + 2];
    assign w_a3 = w_ak[4*c + 3];
    assign w_mix = {
      gf_mul(8'h0e, w_a0) ^ gf_mul(8'h0b, w_a1) ^ gf_mul(8'h0d, w_a2) ^ gf_mul(8'h09, w_a3),
      gf_mul(8'h09, w_a0) ^ gf_mul(8'h0e, w_a1) ^ gf_mul(8'h0b, w_a2) ^ gf_mul(8'h0d, w_a3),
      gf_mul(8'h0d, w_a0) ^ gf_mul(8'h09, w_a1) ^ gf_mul(8'h0e, w_a2) ^ gf_mul(8'h0b, w_a3),
      gf_mul(8'h0b, w_a0) ^ gf_mul(8'h0d, w_a1) ^ gf_mul(8'h09, w_a2) ^ gf_mul(8'h0e, w_a3)
    };
    assign o_state[127 - 32*c -: 32] = i_mix_en ? w_mix : {w_a0, w_a1, w_a2, w_a3};
  end

endmodule

`default_nettype wire

// File: rtl/decryptor.sv
// ============================================================================
// Module   : decryptor
// Purpose  : Iterative AES-128 decryptor, one round per clock, fixed latency
// Revision : 1.0
// ============================================================================
`default_nettype none

module decryptor
  import decryptor_pkg::*;
#(
  parameter int NR = c_nr_aes128
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] c_last_kidx = 4'(NR);
  localparam logic [3:0] c_first_rnd = 4'(NR - 1);

  fsm_t         r_fsm, w_fsm_nxt;
  logic [127:0] r_ct;
  logic [127:0] r_st;
  logic [127:0] r_rk [0:NR];
  logic [3:0]   r_kcnt;
  logic [3:0]   r_rnd;

  logic [127:0] w_prev_rk, w_next_rk, w_cur_rk, w_round;
  logic [31:0]  w_rot, w_sub, w_tmp, w_k0, w_k1, w_k2, w_k3;
  logic         w_mix_en;

  // Forward key schedule, one round key per cycle
  assign w_prev_rk = r_rk[r_kcnt - 4'd1];
  assign w_rot     = {w_prev_rk[23:0], w_prev_rk[31:24]};
  assign w_sub     = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_tmp     = w_sub ^ {rcon(r_kcnt), 24'h000000};
  assign w_k0      = w_prev_rk[127:96] ^ w_tmp;
  assign w_k1      = w_prev_rk[95:64]  ^ w_k0;
  assign w_k2      = w_prev_rk[63:32]  ^ w_k1;
  assign w_k3      = w_prev_rk[31:0]   ^ w_k2;
  assign w_next_rk = {w_k0, w_k1, w_k2, w_k3};

  // rnd has already decremented to 0 on entry to FINAL, selecting rk[0]
  assign w_cur_rk = r_rk[r_rnd];
  assign w_mix_en = (r_fsm == ST_ROUND);

  inv_round u_inv_round (
    .i_state  (r_st),
    .i_rk     (w_cur_rk),
    .i_mix_en (w_mix_en),
    .o_state  (w_round)
  );

  assign busy = (r_fsm != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE:   if (start) w_fsm_nxt = ST_EXPAND;
      ST_EXPAND: if (r_kcnt == c_last_kidx) w_fsm_nxt = ST_INIT;
      ST_INIT:   w_fsm_nxt = ST_ROUND;
      ST_ROUND:  if (r_rnd == 4'd1) w_fsm_nxt = ST_FINAL;
      ST_FINAL:  w_fsm_nxt = ST_IDLE;
      default:   w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ct      <= '0;
      r_st      <= '0;
      r_kcnt    <= '0;
      r_rnd     <= '0;
      plaintext <= '0;
      done      <= 1'b0;
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (start) begin
            r_ct    <= ciphertext;
            r_rk[0] <= key;
            r_kcnt  <= 4'd1;
          end
        end
        ST_EXPAND: begin
          r_rk[r_kcnt] <= w_next_rk;
          r_kcnt       <= r_kcnt + 4'd1;
        end
        ST_INIT: begin
          r_st  <= r_ct ^ r_rk[c_last_kidx];
          r_rnd <= c_first_rnd;
        end
        ST_ROUND: begin
          r_st  <= w_round;
          r_rnd <= r_rnd - 4'd1;
        end
        ST_FINAL: begin
          plaintext <= w_round;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
